nonce_tx_queue: RTL and testbench



---
 rtl/nonce_tx_queue.sv | 143 ++++++++++++++
 tb/tb_nonce_tx_queue.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_tx_queue.sv
// nonce_tx_queue: buffers 32-bit golden nonces in a FIFO and serialises each one MSB-first
// to the UART TX core. Define NONCE_TX_SYNC_EN to prefix every frame with SYNC_BYTE.
module nonce_tx_queue #(
    parameter int         DEPTH_LOG2 = 3,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] nonce_in,
    input  logic        nonce_valid,
    output logic        full,
    output logic        empty,
    output logic [7:0]  tx_byte,
    output logic        start,
    input  logic        busy,
    output logic        idle,
    output logic [7:0]  drop_count,
    output logic [2:0]  state_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

`ifdef NONCE_TX_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif
    localparam logic [2:0] LAST_IDX = SYNC_EN ? 3'd4 : 3'd3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SEND    = 3'd2;
    localparam logic [2:0] S_WAIT_HI = 3'd3;
    localparam logic [2:0] S_WAIT_LO = 3'd4;

    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, empty_q;
    logic [2:0]            state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [31:0]           shift_q, shift_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic [7:0]            drop_q, drop_d;
    logic                  push, pop;
    logic [31:0]           head;

    assign push = nonce_valid && !full_q;
    assign pop  = (state_q == S_LOAD);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        if (nonce_valid && full_q && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        tx_byte_d = tx_byte_q;
        case (state_q)
            S_IDLE: if (!empty_q) state_d = S_LOAD;
            S_LOAD: begin
                idx_d   = 3'd0;
                state_d = S_SEND;
                if (SYNC_EN) begin
                    tx_byte_d = SYNC_BYTE;
                    shift_d   = head;
                end else begin
                    tx_byte_d = head[31:24];
                    shift_d   = {head[23:0], 8'h00};
                end
            end
            S_SEND:    if (!busy) state_d = S_WAIT_HI;
            S_WAIT_HI: if (busy)  state_d = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        // shift_q always holds the not-yet-sent bytes left-aligned
                        idx_d     = idx_q + 3'd1;
                        tx_byte_d = shift_q[31:24];
                        shift_d   = {shift_q[23:0], 8'h00};
                        state_d   = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= nonce_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            shift_q   <= 32'h0;
            tx_byte_q <= 8'h00;
            drop_q    <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            // full tracks the new count so a burst can never overrun; empty trails the
            // stored count by one edge, giving the 3-cycle push-to-start latency
            full_q    <= (count_d == DEPTH_CNT);
            empty_q   <= (count_q == '0);
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            tx_byte_q <= tx_byte_d;
            drop_q    <= drop_d;
        end
    end

    assign full       = full_q;
    assign empty      = empty_q;
    assign tx_byte    = tx_byte_q;
    assign start      = (state_q == S_SEND) && !busy;
    assign idle       = (state_q == S_IDLE) && empty_q;
    assign drop_count = drop_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_nonce_tx_queue.sv
// Bench for nonce_tx_queue: directed scenarios and randomized batches checked against an
// expected byte stream and a behavioural UART TX model that answers each start with busy.
module tb_nonce_tx_queue;

    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
`ifdef NONCE_TX_SYNC_EN
    localparam int FRAME = 5;
`else
    localparam int FRAME = 4;
`endif
    localparam int MAXB = 1024;

    logic        clk;
    logic        rst_n;
    logic [31:0] nonce_in;
    logic        nonce_valid;
    logic        full;
    logic        empty;
    logic [7:0]  tx_byte;
    logic        start;
    logic        busy;
    logic        idle;
    logic [7:0]  drop_count;
    logic [2:0]  state_o;

    logic model_busy;
    logic hold_busy;
    logic slow_busy;
    logic rand_busy;
    assign busy = model_busy | hold_busy;

    int cyc = 0;
    int start_cnt = 0;
    int served_cnt = 0;
    int viol_busy = 0;
    int viol_consec = 0;
    int last_start_cyc = -10;
    logic [7:0] obs_byte [MAXB];
    int         obs_cyc  [MAXB];
    int         fall_cyc [MAXB];

    logic [7:0] exp_q[$];
    int rd_i = 0;
    int n_tests = 0;
    int n_fail = 0;

    nonce_tx_queue #(.DEPTH_LOG2(3), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nonce_in   (nonce_in),
        .nonce_valid(nonce_valid),
        .full       (full),
        .empty      (empty),
        .tx_byte    (tx_byte),
        .start      (start),
        .busy       (busy),
        .idle       (idle),
        .drop_count (drop_count),
        .state_o    (state_o)
    );

    // clock / reset-free cycle counter
    initial begin : clock_gen
        clk = 1'b0;
        forever begin
            #5 clk = 1'b1;
            cyc = cyc + 1;
            #5 clk = 1'b0;
        end
    end

    initial begin : watchdog
        #(60000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Monitor: records every start pulse with its byte and cycle
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (start === 1'b1 && start_cnt < MAXB) begin
                if (busy !== 1'b0) viol_busy++;
                if (last_start_cyc == cyc - 1) viol_consec++;
                last_start_cyc = cyc;
                obs_byte[start_cnt] = tx_byte;
                obs_cyc[start_cnt]  = cyc;
                start_cnt++;
            end
        end
    end

    // UART TX model: samples start on the edge, raises busy dly cycles later, holds len cycles
    initial begin : uart_driver
        int k, dly, len;
        model_busy = 1'b0;
        forever begin
            @(posedge clk);
            if (served_cnt != start_cnt) begin
                k = served_cnt;
                served_cnt++;
                dly = slow_busy ? 4 : (rand_busy ? int'($urandom_range(1, 3)) : 1);
                len = rand_busy ? int'($urandom_range(2, 6)) : 3;
                repeat (dly - 1) @(posedge clk);
                #1 model_busy = 1'b1;
                repeat (len) @(posedge clk);
                #1 model_busy = 1'b0;
                fall_cyc[k] = cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        nonce_in    = v;
        nonce_valid = 1'b1;
        @(posedge clk);
        #1;
        nonce_valid = 1'b0;
    endtask

    function automatic void add_frame(input logic [31:0] v);
`ifdef NONCE_TX_SYNC_EN
        exp_q.push_back(8'hA5);
`endif
        exp_q.push_back(v[31:24]);
        exp_q.push_back(v[23:16]);
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
    endfunction

    // Scoreboard drain: compares each observed byte with the next expected one
    task automatic check_bytes(input string tag);
        int pos;
        int budget;
        logic [7:0] e;
        pos = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            budget = 0;
            while (start_cnt <= rd_i && budget < 500) begin
                step();
                budget++;
            end
            if (start_cnt <= rd_i) begin
                check({tag, "_byte_timeout"}, 32'(start_cnt - rd_i), 32'd1);
                exp_q.delete();
            end else begin
                check({tag, "_byte"}, {24'h0, obs_byte[rd_i]}, {24'h0, e});
                if (pos != 0)
                    check({tag, "_gap"}, 32'(obs_cyc[rd_i] - fall_cyc[rd_i - 1]), 32'd1);
                rd_i++;
                pos = (pos + 1) % FRAME;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int budget;
        budget = 0;
        while (!(idle === 1'b1 && busy === 1'b0) && budget < 500) begin
            step();
            budget++;
        end
        check(tag, 32'(idle), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_full"},  32'(full),       32'd0);
        check({tag, "_empty"}, 32'(empty),      32'd1);
        check({tag, "_txbyte"}, 32'(tx_byte),   32'd0);
        check({tag, "_start"}, 32'(start),      32'd0);
        check({tag, "_idle"},  32'(idle),       32'd1);
        check({tag, "_drop"},  32'(drop_count), 32'd0);
    endtask

    initial begin : main
        int first_i, push_edge, budget, n;
        logic [31:0] v;
        logic [31:0] ovf [10];

        rst_n = 1'b0; nonce_in = 32'h0; nonce_valid = 1'b0;
        hold_busy = 1'b0; slow_busy = 1'b0; rand_busy = 1'b0;
        repeat (3) step();
        check_reset_values("reset");
        rst_n = 1'b1;
        step();
        check("post_reset_idle", 32'(idle), 32'd1);

        // Single nonce with first-start latency
        first_i = start_cnt;
        push_edge = cyc + 1;
        add_frame(32'hDEADBEEF);
        push(32'hDEADBEEF);
        check_bytes("single");
        check("single_latency", 32'(obs_cyc[first_i] - push_edge), 32'd3);
        wait_idle("single_idle");

        // Back-to-back pushes
        add_frame(32'h00000001);
        add_frame(32'h12345678);
        push(32'h00000001);
        push(32'h12345678);
        check_bytes("b2b");
        wait_idle("b2b_idle");

        // UART raises busy 3 cycles late
        slow_busy = 1'b1;
        add_frame(32'h5A5AC3C3);
        push(32'h5A5AC3C3);
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (start !== 1'b1 && budget < 50);
        check("slow_first_start", 32'(start), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("slow_hold_wait_hi", 32'(state_o), 32'(ST_WAIT_HI));
            check("slow_no_extra_start", 32'(start), 32'd0);
        end
        step();
        check_bytes("slow");
        wait_idle("slow_idle");
        slow_busy = 1'b0;

        // Randomized batches with random UART timing
        rand_busy = 1'b1;
        for (int b = 0; b < 5; b++) begin
            n = int'($urandom_range(1, 8));
            for (int i = 0; i < n; i++) begin
                v = $urandom;
                add_frame(v);
                push(v);
                repeat ($urandom_range(0, 2)) step();
            end
            check_bytes("rand");
            wait_idle("rand_idle");
        end
        check("rand_no_drops", 32'(drop_count), 32'd0);
        rand_busy = 1'b0;

        // Overflow: 10 pushes while the UART is held busy
        hold_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ovf[i] = $urandom;
            if (i < 9) add_frame(ovf[i]);
        end
        for (int i = 0; i < 10; i++) push(ovf[i]);
        step();
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_empty", 32'(empty), 32'd0);
        check("ovf_drop", 32'(drop_count), 32'd1);

        // Push during the LOAD pop while full: must still be rejected
        hold_busy = 1'b0;
        budget = 0;
        do begin
            step();
            budget++;
        end while (state_o !== ST_LOAD && budget < 300);
        check("fullpop_in_load", 32'(state_o), 32'(ST_LOAD));
        check("fullpop_full", 32'(full), 32'd1);
        push(32'hBAD0BAD0);
        check("fullpop_drop", 32'(drop_count), 32'd2);
        check("fullpop_full_after", 32'(full), 32'd0);
        check_bytes("overflow");
        wait_idle("overflow_idle");

        // Reset after the second byte of a frame
        first_i = start_cnt;
`ifdef NONCE_TX_SYNC_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'hCA);
`else
        exp_q.push_back(8'hCA);
        exp_q.push_back(8'hFE);
`endif
        push(32'hCAFEF00D);
        check_bytes("midreset_pre");
        check("midreset_two_bytes", 32'(start_cnt - first_i), 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        step();
        step();
        rst_n = 1'b1;
        rd_i = start_cnt;
        add_frame(32'h0123ABCD);
        push(32'h0123ABCD);
        check_bytes("after_reset");
        wait_idle("after_reset_idle");

        check("no_start_while_busy", 32'(viol_busy), 32'd0);
        check("no_consecutive_start", 32'(viol_consec), 32'd0);
        check("no_extra_bytes", 32'(start_cnt - rd_i), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
